uart_rx_ovs: RTL and testbench

Parametrised, oversampling UART receiver for the board-level serial path. It supports a configurable data width, a runtime baud divider, optional even/odd parity, and one or two stop bits. It adds break detection and a valid/ready output holding register with overrun reporting. It sits between the synchronised pin `rx_i` and any sysclk-domain consumer (FIFO, command decoder).

---
 rtl/uart_rx_ovs.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_ovs.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with majority voting, break detection and a held-word output.
// Optional parity checking is built in when UART_RX_PARITY_EN is defined.
module uart_rx_ovs #(
    parameter int DATA_W    = 8,
    parameter int OVS       = 16,
    parameter int DIV_W     = 16,
    parameter int STOP_BITS = 1
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic [DIV_W-1:0]  baud_div_i,
    input  logic [1:0]        parity_mode_i,
    input  logic              rx_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              frame_err_o,
    output logic              parity_err_o,
    output logic              overrun_o,
    output logic              break_o,
    output logic              busy_o
);
    localparam int SCW = $clog2(OVS);
    localparam int BNW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HI
    } state_t;

    state_t            r_state;
    logic [1:0]        r_sync;
    logic              r_rx_d;
    logic [1:0]        r_arm;
    logic [DIV_W-1:0]  r_presc;
    logic [DIV_W-1:0]  r_div;
    logic [SCW-1:0]    r_scnt;
    logic [2:0]        r_smp;
    logic [BNW-1:0]    r_bitn;
    logic              r_stopn;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic              r_pe;
    logic              r_zero;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_fe_o;
    logic              r_pe_o;
    logic              r_ovr;
    logic              r_brk;

    logic w_rx_s, w_fall, w_tick, w_bdone, w_bit;
    logic w_stop_done, w_brk, w_done, w_par_on, w_odd;

    assign w_rx_s = r_sync[1];
    // The chain's reset value is not a real line sample, so edges wait until it has flushed.
    assign w_fall = (r_arm == 2'd3) && r_rx_d && !w_rx_s;
    assign w_tick = (r_state != S_IDLE) && (r_presc == r_div);
    assign w_bdone = w_tick && (r_scnt == SCW'(OVS - 1));
    assign w_bit = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);

    assign w_stop_done = (r_state == S_STOP) && w_bdone;
    assign w_brk = w_stop_done && !w_bit && !r_stopn && r_zero;
    assign w_done = w_stop_done && !w_brk && (!w_bit || r_stopn == 1'(STOP_BITS - 1));

`ifdef UART_RX_PARITY_EN
    assign w_par_on = (parity_mode_i == 2'b01) || (parity_mode_i == 2'b10);
    assign w_odd = (parity_mode_i == 2'b10);
    assign parity_err_o = r_pe_o;
`else
    logic w_unused;
    assign w_par_on = 1'b0;
    assign w_odd = 1'b0;
    assign parity_err_o = 1'b0;
    assign w_unused = ^{parity_mode_i, r_pe_o};
`endif

    assign data_o = r_data;
    assign valid_o = r_valid;
    assign frame_err_o = r_fe_o;
    assign overrun_o = r_ovr;
    assign break_o = r_brk;
    assign busy_o = (r_state != S_IDLE);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sync  <= 2'b11;
            r_rx_d  <= 1'b0;
            r_arm   <= 2'd0;
            r_presc <= '0;
            r_div   <= '0;
            r_scnt  <= '0;
            r_smp   <= '0;
            r_bitn  <= '0;
            r_stopn <= 1'b0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_pe    <= 1'b0;
            r_zero  <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_fe_o  <= 1'b0;
            r_pe_o  <= 1'b0;
            r_ovr   <= 1'b0;
            r_brk   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], rx_i};
            r_rx_d <= w_rx_s;
            if (r_arm != 2'd3)
                r_arm <= r_arm + 2'd1;
            r_ovr <= 1'b0;
            r_brk <= w_brk;

            if (r_state != S_IDLE) begin
                r_presc <= w_tick ? '0 : r_presc + DIV_W'(1);
                if (w_tick) begin
                    r_scnt <= (r_scnt == SCW'(OVS - 1)) ? '0 : r_scnt + SCW'(1);
                    if (r_scnt == SCW'(OVS / 2 - 1)) r_smp[0] <= w_rx_s;
                    if (r_scnt == SCW'(OVS / 2))     r_smp[1] <= w_rx_s;
                    if (r_scnt == SCW'(OVS / 2 + 1)) r_smp[2] <= w_rx_s;
                end
            end

            unique case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_START;
                        r_presc <= '0;
                        r_div   <= baud_div_i;
                        r_scnt  <= '0;
                    end
                end
                S_START: begin
                    if (w_bdone) begin
                        r_state <= w_bit ? S_IDLE : S_DATA;
                        r_bitn  <= '0;
                        r_zero  <= 1'b1;
                        r_par   <= 1'b0;
                        r_pe    <= 1'b0;
                        r_stopn <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (w_bdone) begin
                        r_shift <= {w_bit, r_shift[DATA_W-1:1]};
                        r_zero  <= r_zero & ~w_bit;
                        r_par   <= r_par ^ w_bit;
                        if (r_bitn == BNW'(DATA_W - 1))
                            r_state <= w_par_on ? S_PARITY : S_STOP;
                        else
                            r_bitn <= r_bitn + BNW'(1);
                    end
                end
                S_PARITY: begin
                    if (w_bdone) begin
                        r_pe    <= (r_par ^ w_bit) != w_odd;
                        r_zero  <= r_zero & ~w_bit;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_bdone) begin
                        if (!w_bit)
                            r_state <= S_WAIT_HI;
                        else if (r_stopn == 1'(STOP_BITS - 1))
                            r_state <= S_IDLE;
                        else
                            r_stopn <= 1'b1;
                    end
                end
                S_WAIT_HI: begin
                    if (w_rx_s)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // A busy consumer keeps the old word; the new frame is dropped.
            if (w_done) begin
                if (!r_valid || ready_i) begin
                    r_data  <= r_shift;
                    r_fe_o  <= !w_bit;
                    r_pe_o  <= r_pe;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
                r_fe_o  <= 1'b0;
                r_pe_o  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_ovs.sv
// Bench for uart_rx_ovs: directed and random frames checked against a frame-level model.
module tb_uart_rx_ovs;
    logic        sysclk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] baud_div_i = 16'd3;
    logic [1:0]  parity_mode_i = 2'b00;
    logic        rx_i = 1'b1;
    logic        ready_i = 1'b1;
    logic [7:0]  data_o;
    logic        valid_o, frame_err_o, parity_err_o;
    logic        overrun_o, break_o, busy_o;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } word_t;

    int     vectors = 0;
    int     miscompares = 0;
    int     bt = 64;
    longint cyc = 0;
    longint last_vcyc = 0;
    int     n_vcyc = 0;
    int     n_ovr = 0;
    int     n_brk = 0;
    word_t  q[$];

    uart_rx_ovs dut (
        .sysclk(sysclk),
        .reset(reset),
        .baud_div_i(baud_div_i),
        .parity_mode_i(parity_mode_i),
        .rx_i(rx_i),
        .ready_i(ready_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .frame_err_o(frame_err_o),
        .parity_err_o(parity_err_o),
        .overrun_o(overrun_o),
        .break_o(break_o),
        .busy_o(busy_o)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc++;

    always @(negedge sysclk) begin
        if (valid_o) begin
            n_vcyc++;
            last_vcyc = cyc;
            if (ready_i)
                q.push_back({data_o, frame_err_o, parity_err_o});
        end
        if (overrun_o) n_ovr++;
        if (break_o) n_brk++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit has_par(input logic [1:0] m);
        return PAR_EN && (m == 2'b01 || m == 2'b10);
    endfunction

    function automatic word_t expect_word(input logic [7:0] d, input bit pb,
                                          input bit stopv, input logic [1:0] m);
        word_t w;
        int    ones;
        ones = $countones(d) + int'(pb);
        w.d = d;
        w.fe = !stopv;
        w.pe = has_par(m) ? ((ones % 2) != ((m == 2'b10) ? 1 : 0)) : 1'b0;
        return w;
    endfunction

    function automatic bit is_break(input logic [7:0] d, input bit pb,
                                    input bit stopv, input logic [1:0] m);
        return (d == 8'h00) && !stopv && (!has_par(m) || !pb);
    endfunction

    task automatic send(input logic [7:0] d, input bit pb, input bit stopv);
        rx_i = 1'b0;
        step(bt);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            step(bt);
        end
        if (has_par(parity_mode_i)) begin
            rx_i = pb;
            step(bt);
        end
        rx_i = stopv;
        step(bt);
        rx_i = 1'b1;
        step(bt);
    endtask

    task automatic frame_check(input string tag, input logic [7:0] d,
                               input bit pb, input bit stopv);
        int    q0;
        int    b0;
        word_t w;
        q0 = q.size();
        b0 = n_brk;
        send(d, pb, stopv);
        if (is_break(d, pb, stopv, parity_mode_i)) begin
            chk($sformatf("%s_brk", tag), 32'(n_brk - b0), 32'd1);
            chk($sformatf("%s_noword", tag), 32'(q.size() - q0), 32'd0);
        end else begin
            chk($sformatf("%s_cnt", tag), 32'(q.size() - q0), 32'd1);
            chk($sformatf("%s_nobrk", tag), 32'(n_brk - b0), 32'd0);
            if (q.size() > q0) begin
                w = q[q.size() - 1];
                chk($sformatf("%s_word", tag), 32'(w),
                    32'(expect_word(d, pb, stopv, parity_mode_i)));
            end
        end
    endtask

    initial begin
        longint c0;
        int     q0, b0, o0, v0;
        logic [7:0] d;
        bit     pb, sv;

        step(5);
        chk("reset_out", 32'({data_o, valid_o, frame_err_o, parity_err_o,
                              overrun_o, break_o, busy_o}), 32'd0);
        reset = 1'b0;
        step(10);

        v0 = n_vcyc;
        c0 = cyc;
        frame_check("a5", 8'hA5, 1'b0, 1'b1);
        chk("a5_pulse", 32'(n_vcyc - v0), 32'd1);
        chk("a5_latency", 32'((last_vcyc - c0 >= 640) && (last_vcyc - c0 <= 645)), 32'd1);

        parity_mode_i = 2'b01;
        frame_check("par_even", 8'h03, 1'b1, 1'b1);
        parity_mode_i = 2'b10;
        frame_check("par_odd", 8'h03, 1'b1, 1'b1);
        parity_mode_i = 2'b00;

        v0 = n_vcyc;
        rx_i = 1'b0;
        step(10);
        rx_i = 1'b1;
        step(bt);
        chk("glitch_busy", 32'(busy_o), 32'd0);
        chk("glitch_novalid", 32'(n_vcyc - v0), 32'd0);

        ready_i = 1'b0;
        o0 = n_ovr;
        send(8'h11, 1'b0, 1'b1);
        send(8'h22, 1'b0, 1'b1);
        chk("ovr_pulse", 32'(n_ovr - o0), 32'd1);
        chk("ovr_hold", 32'(data_o), 32'h11);
        chk("ovr_valid", 32'(valid_o), 32'd1);
        q0 = q.size();
        ready_i = 1'b1;
        step(1);
        chk("ovr_drop", 32'(valid_o), 32'd0);
        chk("ovr_deliv", 32'(q.size() - q0), 32'd1);
        if (q.size() > q0)
            chk("ovr_word", 32'(q[q.size() - 1]), 32'(expect_word(8'h11, 1'b0, 1'b1, 2'b00)));

        q0 = q.size();
        b0 = n_brk;
        rx_i = 1'b0;
        step(12 * bt);
        rx_i = 1'b1;
        step(2 * bt);
        chk("brk_pulse", 32'(n_brk - b0), 32'd1);
        chk("brk_noword", 32'(q.size() - q0), 32'd0);
        frame_check("post_brk", 8'h5A, 1'b0, 1'b1);

        frame_check("ferr", 8'h7E, 1'b0, 1'b0);

        q0 = q.size();
        b0 = n_brk;
        o0 = n_ovr;
        rx_i = 1'b0;
        step(bt);
        rx_i = 1'b1;
        step(3 * bt);
        reset = 1'b1;
        step(3);
        chk("rst_out", 32'({data_o, valid_o, frame_err_o, parity_err_o,
                            overrun_o, break_o, busy_o}), 32'd0);
        reset = 1'b0;
        step(12 * bt);
        chk("rst_noword", 32'(q.size() - q0), 32'd0);
        chk("rst_nobrk", 32'(n_brk - b0), 32'd0);
        chk("rst_noovr", 32'(n_ovr - o0), 32'd0);

        v0 = n_vcyc;
        reset = 1'b1;
        rx_i = 1'b0;
        step(3);
        reset = 1'b0;
        step(3 * bt);
        chk("lowrst_busy", 32'(busy_o), 32'd0);
        chk("lowrst_novalid", 32'(n_vcyc - v0), 32'd0);
        rx_i = 1'b1;
        step(bt);

        baud_div_i = 16'd0;
        bt = 16;
        frame_check("div0", 8'h3C, 1'b0, 1'b1);
        baud_div_i = 16'd3;
        bt = 64;

        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            pb = 1'($urandom_range(0, 1));
            sv = ($urandom_range(0, 3) != 0);
            parity_mode_i = 2'($urandom_range(0, 3));
            if (i == 3) begin
                d = 8'h00;
                sv = 1'b0;
                pb = 1'b0;
            end
            frame_check($sformatf("rnd%0d", i), d, pb, sv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
